// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding request, byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_CHECK_EN completes misaligned H/W accesses locally with o_misaligned set.
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic              o_mem_we,
    output logic [XLEN/8-1:0] o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misaligned
);
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    state_e            state_q, state_d;
    lsu_size_e         size_q, size_d, size_c;
    logic [1:0]        off_q, off_d, off_c;
    logic              uns_q, uns_d;
    logic              ready_q, ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d, be_c;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d, wdata_c;
    logic [XLEN-1:0]   rdata_q, rdata_d, lane_c, ext_c;
    logic              done_q, done_d;
    logic              mis_q, mis_d, mis_c;

    // Request decode: width, effective lane offset, byte enables, replicated store data
    always_comb begin
        size_c = SZ_W;
        if (i_funct3[1:0] == 2'b00) size_c = SZ_B;
        else if (i_funct3[1:0] == 2'b01) size_c = SZ_H;

        mis_c   = 1'b0;
        off_c   = 2'b00;
        be_c    = {BE_W{1'b1}};
        wdata_c = i_wdata;
        case (size_c)
            SZ_B: begin
                off_c   = i_addr[1:0];
                be_c    = BE_W'(4'b0001) << i_addr[1:0];
                wdata_c = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                off_c   = {i_addr[1], 1'b0};
                be_c    = BE_W'(4'b0011) << {i_addr[1], 1'b0};
                wdata_c = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        mis_c = ((size_c == SZ_H) && i_addr[0]) ||
                ((size_c == SZ_W) && (i_addr[1:0] != 2'b00));
`endif
    end

    // Load response lane select and sign/zero extension
    always_comb begin
        lane_c = i_mem_rdata >> {off_q, 3'b000};
        ext_c  = lane_c;
        case (size_q)
            SZ_B: ext_c = uns_q ? {{(XLEN-8){1'b0}}, lane_c[7:0]}
                                : {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
            SZ_H: ext_c = uns_q ? {{(XLEN-16){1'b0}}, lane_c[15:0]}
                                : {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
            default: ;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mis_d       = mis_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    mis_d = mis_c;
                    if (mis_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_REQ;
                        size_d      = size_c;
                        off_d       = off_c;
                        uns_d       = i_funct3[2];
                        mem_we_d    = i_we;
                        mem_addr_d  = {i_addr[XLEN-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_ready) state_d = mem_we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    rdata_d = ext_c;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d     = (state_d == S_IDLE);
        mem_valid_d = (state_d == S_REQ);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            size_q      <= SZ_W;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            ready_q     <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            ready_q     <= ready_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_mem_valid  = mem_valid_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_be     = mem_be_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_done       = done_q;
    assign o_rdata      = rdata_q;
    assign o_misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level access model; honours LSU_MISALIGN_CHECK_EN.
module tb_load_store_unit;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misaligned;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rdata = '0;

    load_store_unit #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we), .i_funct3(i_funct3),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_done(o_done),
        .o_rdata(o_rdata), .o_misaligned(o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One access, driven and sampled on falling edges; expectations from byte arithmetic
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mrdata,
                          input int rdy_dly, input int rv_dly);
        int bytes, off, eff, be_i;
        logic mis;
        logic [31:0] exp_addr, exp_wd, exp_rd, mask;
        logic [3:0] exp_be;
        bytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = int'(addr[1:0]);
        eff   = (off / bytes) * bytes;
        mis   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis   = (off % bytes) != 0;
`endif
        be_i     = ((1 << bytes) - 1) << eff;
        exp_be   = be_i[3:0];
        exp_addr = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % bytes) +: 8];
        exp_rd = mrdata >> (8 * eff);
        if (bytes < 4) begin
            mask   = (32'h1 << (8 * bytes)) - 32'h1;
            exp_rd = exp_rd & mask;
            if (!f3[2] && exp_rd[8*bytes-1]) exp_rd = exp_rd | ~mask;
        end

        @(negedge i_clk);
        check("ready_idle", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        @(negedge i_clk);
        i_valid = 1'b0; i_addr = $urandom; i_wdata = $urandom;
        if (mis) begin
            check("mis_done", 32'(o_done), 32'd1);
            check("mis_flag", 32'(o_misaligned), 32'd1);
            check("mis_no_mem", 32'(o_mem_valid), 32'd0);
            check("mis_rdata_hold", o_rdata, model_rdata);
            @(negedge i_clk);
            check("mis_done_pulse", 32'(o_done), 32'd0);
            return;
        end
        check("ready_busy", 32'(o_ready), 32'd0);
        for (int k = 0; k <= rdy_dly; k++) begin
            if (k > 0) @(negedge i_clk);
            check("mem_valid", 32'(o_mem_valid), 32'd1);
            check("mem_addr", o_mem_addr, exp_addr);
            check("mem_we", 32'(o_mem_we), 32'(we));
            check("mem_be", 32'(o_mem_be), 32'(exp_be));
            if (we) check("mem_wdata", o_mem_wdata, exp_wd);
            check("done_early", 32'(o_done), 32'd0);
            i_mem_rvalid = 1'($urandom);
            i_mem_rdata  = $urandom;
            i_mem_ready  = (k == rdy_dly);
        end
        @(negedge i_clk);
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        if (we) begin
            check("st_done", 32'(o_done), 32'd1);
            check("st_mis", 32'(o_misaligned), 32'd0);
            check("st_rdata_hold", o_rdata, model_rdata);
        end else begin
            check("ld_mem_drop", 32'(o_mem_valid), 32'd0);
            for (int k = 0; k < rv_dly; k++) begin
                check("ld_wait_done", 32'(o_done), 32'd0);
                @(negedge i_clk);
            end
            i_mem_rvalid = 1'b1; i_mem_rdata = mrdata;
            @(negedge i_clk);
            i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
            check("ld_done", 32'(o_done), 32'd1);
            check("ld_mis", 32'(o_misaligned), 32'd0);
            check("ld_rdata", o_rdata, exp_rd);
            model_rdata = exp_rd;
        end
        @(negedge i_clk);
        check("done_pulse", 32'(o_done), 32'd0);
    endtask

    initial begin
        logic [2:0] f3s [8];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        repeat (2) @(negedge i_clk);
        check("rst_mem_valid", 32'(o_mem_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_be", 32'(o_mem_be), 32'd0);
        check("rst_addr", o_mem_addr, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);

        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 3);
        check("lb_const", o_rdata, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 3);
        check("lbu_const", o_rdata, 32'h00000080);
        run_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 4, 0);
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1);

        // Reset while waiting for the load response; the late rvalid must be ignored
        @(negedge i_clk);
        i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
        @(negedge i_clk);
        i_valid = 1'b0; i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(o_mem_valid), 32'd0);
        check("rst_mid_addr", o_mem_addr, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_rdata = '0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        check("late_rv_done", 32'(o_done), 32'd0);
        check("late_rv_rdata", o_rdata, 32'd0);
        check("late_rv_mis", 32'(o_misaligned), 32'd0);
        check("late_rv_we", 32'(o_mem_we), 32'd0);
        check("late_rv_ready", 32'(o_ready), 32'd1);
        run_op(1'b0, 3'b001, 32'h402, 32'h0, 32'h8001_7FFF, 1, 0);

        for (int n = 0; n < 150; n++) begin
            run_op(1'($urandom), f3s[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
